mask_prng_pool: RTL



---
 rtl/prng_pool_pkg.sv | 26 ++
 rtl/prng_core_ch.sv | 126 ++++++++++++
 rtl/mask_prng_pool.sv | 112 +++++++++++
 3 files changed

// File: rtl/prng_pool_pkg.sv
// Shared constants, FSM state type and CASR/LFSR step functions for mask_prng_pool.
package prng_pool_pkg;

    localparam int CASR_W = 37;
    localparam int LFSR_W = 43;

    localparam logic [CASR_W-1:0] CASR_RST   = 37'h0_1000_0000;
    localparam logic [LFSR_W-1:0] LFSR_RST   = 43'h000_1000_0001;
    localparam logic [31:0]       SEED_FORCE = 32'h1000_0000;
    localparam logic [31:0]       SALT_MUL   = 32'h9E37_79B9;

    // ST_ prefix keeps the enum clear of the top-level WARMUP parameter.
    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } pool_state_t;

    function automatic logic [CASR_W-1:0] next_casr(input logic [CASR_W-1:0] c);
        return {c[35:0], c[36]} ^ {c[0], c[36:1]} ^ {9'b0, c[27], 27'b0};
    endfunction

    function automatic logic [LFSR_W-1:0] next_lfsr(input logic [LFSR_W-1:0] l);
        return {l[41:0], l[42]} ^ {1'b0, l[42], 20'b0, l[42], 18'b0, l[42], 1'b0};
    endfunction

endpackage

// File: rtl/prng_core_ch.sv
// One generator channel: CASR/LFSR core, 2-entry output FIFO and, with
// PRNG_HEALTH_EN defined, a repetition-count health test.
module prng_core_ch
    import prng_pool_pkg::*;
#(
    parameter int OUT_W        = 32,
    parameter int CH_IDX       = 0,
    parameter int REPEAT_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [31:0]      seed,
    input  logic             step_warm,
    input  logic             run_en,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             alarm
);

    if (REPEAT_LIMIT < 2 || REPEAT_LIMIT > 15) begin : g_bad_limit
        $error("prng_core_ch: REPEAT_LIMIT must be within 2..15");
    end

    localparam logic [31:0] SALT = SALT_MUL * 32'(CH_IDX);

    logic [CASR_W-1:0] casr;
    logic [LFSR_W-1:0] lfsr;
    logic [31:0]       salted;
    logic [OUT_W-1:0]  word;
    logic [OUT_W-1:0]  mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic [1:0]        count_nxt;
    logic              pop;
    logic              push;
    logic              alarm_q;

    assign salted    = seed ^ SALT;
    assign word      = lfsr[OUT_W-1:0] ^ casr[OUT_W-1:0];
    assign out_valid = (count != 2'd0) && !alarm_q;
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push      = run_en && ((count != 2'd2) || pop) && !alarm_q;
    assign alarm     = alarm_q;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 2'd1;
        end else if (pop && !push) begin
            count_nxt = count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            casr   <= CASR_RST;
            lfsr   <= LFSR_RST;
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (load) begin
            casr   <= {5'h0, salted} | {5'h0, SEED_FORCE};
            lfsr   <= {10'h0, salted, 1'b0} | {11'h0, SEED_FORCE};
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (step_warm || push) begin
                casr <= next_casr(casr);
                lfsr <= next_lfsr(lfsr);
            end
            if (push) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= alarm_q ? 2'd0 : count_nxt;
        end
    end

`ifdef PRNG_HEALTH_EN
    logic [OUT_W-1:0] prev_word;
    logic             has_prev;
    logic [3:0]       rep_cnt;
    logic [4:0]       rep_inc;

    assign rep_inc = {1'b0, rep_cnt} + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_word <= '0;
            has_prev  <= 1'b0;
            rep_cnt   <= 4'd0;
            alarm_q   <= 1'b0;
        end else if (load) begin
            prev_word <= '0;
            has_prev  <= 1'b0;
            rep_cnt   <= 4'd0;
            alarm_q   <= 1'b0;
        end else if (push) begin
            prev_word <= word;
            has_prev  <= 1'b1;
            if (has_prev && (word == prev_word)) begin
                rep_cnt <= rep_inc[3:0];
                if (rep_inc >= 5'(REPEAT_LIMIT)) begin
                    alarm_q <= 1'b1;
                end
            end else begin
                rep_cnt <= 4'd1;
            end
        end
    end
`else
    assign alarm_q = 1'b0;
`endif

endmodule

// File: rtl/mask_prng_pool.sv
// Multi-channel masking PRNG pool: shared warm-up/run FSM over NUM_CH CASR+LFSR
// channels. Optional health test is enabled by defining PRNG_HEALTH_EN.
//
// state     | meaning
// ST_WARMUP | cores step on enable, words discarded, busy=1, seed not accepted
// ST_RUN    | cores step into per-channel FIFOs, seed handshake accepted
module mask_prng_pool
    import prng_pool_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int OUT_W        = 32,
    parameter int WARMUP       = 64,
    parameter int REPEAT_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    seed_valid,
    output logic                    seed_ready,
    input  logic [31:0]             seed,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*OUT_W-1:0] out_data,
    output logic                    busy,
    output logic [NUM_CH-1:0]       alarm
);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("mask_prng_pool: NUM_CH must be within 1..16");
    end
    if (OUT_W < 1 || OUT_W > 37) begin : g_bad_out_w
        $error("mask_prng_pool: OUT_W must be within 1..37");
    end
    if (WARMUP < 1 || WARMUP > 1023) begin : g_bad_warmup
        $error("mask_prng_pool: WARMUP must be within 1..1023");
    end

    pool_state_t state_q;
    pool_state_t state_d;
    logic [9:0]  warm_cnt;
    logic [9:0]  warm_cnt_d;
    logic        step_warm;
    logic        run_en;
    logic        load;

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt;
        seed_ready = 1'b0;
        busy       = 1'b0;
        step_warm  = 1'b0;
        run_en     = 1'b0;
        load       = 1'b0;
        case (state_q)
            ST_WARMUP: begin
                busy = 1'b1;
                if (enable) begin
                    step_warm = 1'b1;
                    if (warm_cnt == 10'(WARMUP - 1)) begin
                        state_d    = ST_RUN;
                        warm_cnt_d = 10'd0;
                    end else begin
                        warm_cnt_d = warm_cnt + 10'd1;
                    end
                end
            end
            ST_RUN: begin
                seed_ready = 1'b1;
                run_en     = enable;
                if (seed_valid) begin
                    load       = 1'b1;
                    state_d    = ST_WARMUP;
                    warm_cnt_d = 10'd0;
                end
            end
            default: begin
                state_d    = ST_WARMUP;
                warm_cnt_d = 10'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_WARMUP;
            warm_cnt <= 10'd0;
        end else begin
            state_q  <= state_d;
            warm_cnt <= warm_cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        prng_core_ch #(
            .OUT_W        (OUT_W),
            .CH_IDX       (i),
            .REPEAT_LIMIT (REPEAT_LIMIT)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load),
            .seed      (seed),
            .step_warm (step_warm),
            .run_en    (run_en),
            .out_ready (out_ready[i]),
            .out_valid (out_valid[i]),
            .out_data  (out_data[i*OUT_W +: OUT_W]),
            .alarm     (alarm[i])
        );
    end

endmodule
